// File: rtl/gcd_pkg.sv
// Shared types and constants for the gcd scheduler slice.
// Carries the scheduler state encoding and the width/requester limits.
package gcd_pkg;

  localparam int GCD_XLEN     = 32;
  localparam int GCD_NREQ_MAX = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } sched_state_e;

endpackage

// File: rtl/gcd_sched_if.sv
// Requester and core-side bundle of gcd_sched.
// slave: the scheduler. master: the requesters plus the gcd core.
interface gcd_sched_if import gcd_pkg::*; #(
  parameter int XLEN = GCD_XLEN,
  parameter int NREQ = 4
) ();

  logic [NREQ-1:0]      req_valid_i;
  logic [NREQ-1:0]      req_ready_o;
  logic [NREQ*XLEN-1:0] req_a_i;
  logic [NREQ*XLEN-1:0] req_b_i;
  logic [NREQ-1:0]      rsp_valid_o;
  logic [NREQ-1:0]      rsp_ready_i;
  logic [XLEN-1:0]      rsp_gcd_o;
  logic                 gcd_ld_o;
  logic [XLEN-1:0]      gcd_a_o;
  logic [XLEN-1:0]      gcd_b_o;
  logic                 gcd_ready_i;
  logic                 gcd_valid_i;
  logic [XLEN-1:0]      gcd_result_i;

  modport slave (
    input  req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    input  gcd_ready_i, gcd_valid_i, gcd_result_i,
    output req_ready_o, rsp_valid_o, rsp_gcd_o,
    output gcd_ld_o, gcd_a_o, gcd_b_o
  );

  modport master (
    output req_valid_i, req_a_i, req_b_i, rsp_ready_i,
    output gcd_ready_i, gcd_valid_i, gcd_result_i,
    input  req_ready_o, rsp_valid_o, rsp_gcd_o,
    input  gcd_ld_o, gcd_a_o, gcd_b_o
  );

endinterface

// File: rtl/gcd_sched_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or
// after ptr, searching upward and wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 any
);

  localparam int IW = $clog2(N);

  always_comb begin
    int idx;
    idx     = 0;
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!any && req[idx]) begin
        any          = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/gcd_sched.sv
// Round-robin scheduler sharing one gcd core among NREQ requesters,
// with a bypass that answers zero-operand pairs without the core.
module gcd_sched import gcd_pkg::*; #(
  parameter int XLEN = GCD_XLEN,
  parameter int NREQ = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  gcd_sched_if.slave              bus,
  output logic                    busy_o,
  output logic [$clog2(NREQ)-1:0] owner_o
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > GCD_NREQ_MAX) begin : g_nreq_check
    $error("gcd_sched: NREQ must be within 2..GCD_NREQ_MAX");
  end

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (int'(v) == NREQ - 1) ? '0 : v + 1'b1;
  endfunction

  function automatic logic is_bypass(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return (a == '0) || (b == '0);
  endfunction

  sched_state_e    state, state_nxt;
  logic [IW-1:0]   ptr, owner, gnt_idx;
  logic [NREQ-1:0] gnt;
  logic            any;
  logic [XLEN-1:0] a_q, b_q, res_q, a_sel, b_sel;
  logic            grant, bypass, rsp_hs;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req     (bus.req_valid_i),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (any)
  );

  // Grant is masked by reset so req_ready_o stays low while rst_i is high.
  assign grant  = (state == IDLE) && any && bus.gcd_ready_i && !rst_i;
  assign a_sel  = bus.req_a_i[int'(gnt_idx)*XLEN +: XLEN];
  assign b_sel  = bus.req_b_i[int'(gnt_idx)*XLEN +: XLEN];
  assign bypass = is_bypass(a_sel, b_sel);
  assign rsp_hs = (state == RESP) && bus.rsp_ready_i[owner];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt       = state;
    bus.req_ready_o = '0;
    bus.rsp_valid_o = '0;
    bus.gcd_ld_o    = 1'b0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          bus.req_ready_o = gnt;
          state_nxt       = bypass ? RESP : LOAD;
        end
      end
      LOAD: begin
        bus.gcd_ld_o = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (bus.gcd_valid_i) state_nxt = RESP;
      end
      RESP: begin
        bus.rsp_valid_o[owner] = 1'b1;
        if (rsp_hs) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand, result, owner and pointer registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      owner <= '0;
      ptr   <= '0;
    end else begin
      if (grant) begin
        a_q   <= a_sel;
        b_q   <= b_sel;
        owner <= gnt_idx;
        if (bypass) res_q <= a_sel | b_sel;
      end
      if (state == WAIT && bus.gcd_valid_i) res_q <= bus.gcd_result_i;
      if (rsp_hs) ptr <= wrap_inc(owner);
    end
  end

  assign bus.rsp_gcd_o = res_q;
  assign bus.gcd_a_o   = a_q;
  assign bus.gcd_b_o   = b_q;
  assign busy_o        = (state != IDLE);
  assign owner_o       = owner;

endmodule

// File: tb/tb_gcd_sched.sv
// Self-checking bench for gcd_sched with a behavioural gcd core (fixed latency)
// and a transaction-level round-robin reference model.
module tb_gcd_sched;

  localparam int XLEN = 32;
  localparam int NREQ = 4;
  localparam int IW   = $clog2(NREQ);
  localparam int LC   = 5;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  gcd_sched_if #(.XLEN(XLEN), .NREQ(NREQ)) bus ();
  logic          busy_o;
  logic [IW-1:0] owner_o;

  gcd_sched #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .bus     (bus),
    .busy_o  (busy_o),
    .owner_o (owner_o)
  );

  int checks = 0;
  int errors = 0;
  int exp_ptr = 0;

  logic [XLEN-1:0] pa [NREQ];
  logic [XLEN-1:0] pb [NREQ];
  logic [NREQ-1:0] vmask;

  function automatic logic [XLEN-1:0] ref_gcd(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    logic [XLEN-1:0] x, y, t;
    x = a; y = b;
    while (y != 0) begin
      t = x % y; x = y; y = t;
    end
    return x;
  endfunction

  function automatic logic [XLEN-1:0] model_result(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
    return (a == 0 || b == 0) ? (a | b) : ref_gcd(a, b);
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] m);
    for (int k = 0; k < NREQ; k++)
      if (m[(exp_ptr + k) % NREQ]) return (exp_ptr + k) % NREQ;
    return -1;
  endfunction

  // Behavioural core: result pulse LC cycles after the load strobe.
  logic core_busy, core_valid, core_hold, stray;
  int   core_cnt;
  logic [XLEN-1:0] core_res;
  assign bus.gcd_ready_i  = !core_busy && !core_hold;
  assign bus.gcd_valid_i  = core_valid | stray;
  assign bus.gcd_result_i = core_res;

  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      core_busy <= 1'b0; core_valid <= 1'b0; core_cnt <= 0; core_res <= '0;
    end else begin
      core_valid <= 1'b0;
      if (bus.gcd_ld_o && !core_busy) begin
        core_busy <= 1'b1;
        core_cnt  <= LC - 1;
        core_res  <= ref_gcd(bus.gcd_a_o, bus.gcd_b_o);
      end else if (core_busy) begin
        if (core_cnt <= 1) begin
          core_valid <= 1'b1;
          core_busy  <= 1'b0;
        end else core_cnt <= core_cnt - 1;
      end
    end
  end

  task automatic apply();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a_i[i*XLEN +: XLEN] = pa[i];
      bus.req_b_i[i*XLEN +: XLEN] = pb[i];
    end
    bus.req_valid_i = vmask;
  endtask

  // Called just after a rising edge; returns at the falling edge of the grant cycle.
  task automatic wait_grant(output logic [NREQ-1:0] gv, output int waited);
    gv = '0; waited = -1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (bus.req_ready_o !== '0) begin
        gv = bus.req_ready_o; waited = c;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  // Called just after the edge ending the grant cycle; c counts cycles after the grant.
  task automatic wait_rsp(output int lat, output logic [NREQ-1:0] rv, output logic [XLEN-1:0] res,
                          output int ld_cnt, output int ld_at,
                          output logic [XLEN-1:0] la, output logic [XLEN-1:0] lb);
    lat = -1; rv = '0; res = '0; ld_cnt = 0; ld_at = -1; la = '0; lb = '0;
    for (int c = 1; c < 40; c++) begin
      @(negedge clk);
      if (bus.gcd_ld_o === 1'b1) begin
        ld_cnt++;
        if (ld_at < 0) begin ld_at = c; la = bus.gcd_a_o; lb = bus.gcd_b_o; end
      end
      if (bus.rsp_valid_o !== '0) begin
        lat = c; rv = bus.rsp_valid_o; res = bus.rsp_gcd_o;
        return;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic handshake(input int idx);
    bus.rsp_ready_i = '0;
    if (idx >= 0) bus.rsp_ready_i[idx] = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = '0;
    if (idx >= 0) exp_ptr = (idx + 1) % NREQ;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; vmask = '1; apply();
    @(negedge clk);
    checks++; if (bus.req_ready_o !== '0) begin errors++; $display("FAIL reset_req_ready got %b exp 0", bus.req_ready_o); end
    checks++; if (bus.rsp_valid_o !== '0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", bus.rsp_valid_o); end
    checks++; if (bus.rsp_gcd_o !== '0) begin errors++; $display("FAIL reset_rsp_gcd got %0d exp 0", bus.rsp_gcd_o); end
    checks++; if (bus.gcd_ld_o !== 1'b0) begin errors++; $display("FAIL reset_ld got %b exp 0", bus.gcd_ld_o); end
    checks++; if ({bus.gcd_a_o, bus.gcd_b_o} !== '0) begin errors++; $display("FAIL reset_ops got %0d/%0d exp 0/0", bus.gcd_a_o, bus.gcd_b_o); end
    checks++; if ({busy_o, owner_o} !== '0) begin errors++; $display("FAIL reset_busy_owner got %b/%0d exp 0/0", busy_o, owner_o); end
    @(posedge clk); #1;
    rst_i = 1'b0; vmask = '0; apply(); exp_ptr = 0;
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] gv, rv, ev;
    logic [XLEN-1:0] res, la, lb;
    int waited, lat, ld_cnt, ld_at;
    int order [5] = '{0, 1, 2, 3, 0};
    pa[0] = 48;  pb[0] = 18;
    pa[1] = 100; pb[1] = 75;
    pa[2] = 17;  pb[2] = 5;
    pa[3] = 81;  pb[3] = 27;
    vmask = '1; apply();
    for (int n = 0; n < 5; n++) begin
      wait_grant(gv, waited);
      ev = '0; ev[order[n]] = 1'b1;
      checks++; if (gv !== ev) begin errors++; $display("FAIL fair_grant%0d got %b exp %b", n, gv, ev); end
      checks++; if (waited !== 0) begin errors++; $display("FAIL fair_bubble%0d got %0d exp 0", n, waited); end
      @(posedge clk); #1;
      wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
      checks++; if (rv !== ev || lat !== LC + 2) begin errors++; $display("FAIL fair_rsp%0d got %b@%0d exp %b@%0d", n, rv, lat, ev, LC + 2); end
      checks++; if (res !== model_result(pa[order[n]], pb[order[n]])) begin errors++; $display("FAIL fair_res%0d got %0d exp %0d", n, res, model_result(pa[order[n]], pb[order[n]])); end
      handshake(order[n]);
    end
    vmask = '0; apply();
  endtask

  task automatic test_single();
    logic [NREQ-1:0] gv, rv;
    logic [XLEN-1:0] res, la, lb;
    int waited, lat, ld_cnt, ld_at;
    pa[0] = 48; pb[0] = 18; vmask = 4'b0001; apply();
    wait_grant(gv, waited);
    checks++; if (gv !== 4'b0001) begin errors++; $display("FAIL single_grant got %b exp 0001", gv); end
    @(posedge clk); #1;
    vmask = '0; apply();
    wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
    checks++; if (ld_at !== 1 || ld_cnt !== 1) begin errors++; $display("FAIL single_ld got at %0d cnt %0d exp at 1 cnt 1", ld_at, ld_cnt); end
    checks++; if (la !== 48 || lb !== 18) begin errors++; $display("FAIL single_ops got %0d/%0d exp 48/18", la, lb); end
    checks++; if (lat !== 7 || rv !== 4'b0001) begin errors++; $display("FAIL single_rsp got %b@%0d exp 0001@7", rv, lat); end
    checks++; if (res !== 6) begin errors++; $display("FAIL single_res got %0d exp 6", res); end
    handshake(0);
  endtask

  task automatic test_bypass();
    logic [NREQ-1:0] gv, rv;
    logic [XLEN-1:0] res, la, lb;
    int waited, lat, ld_cnt, ld_at;
    logic [XLEN-1:0] bv [2] = '{35, 0};
    for (int n = 0; n < 2; n++) begin
      pa[2] = 0; pb[2] = bv[n]; vmask = 4'b0100; apply();
      wait_grant(gv, waited);
      checks++; if (gv !== 4'b0100) begin errors++; $display("FAIL bypass_grant%0d got %b exp 0100", n, gv); end
      @(posedge clk); #1;
      vmask = '0; apply();
      wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
      checks++; if (lat !== 1 || rv !== 4'b0100) begin errors++; $display("FAIL bypass_rsp%0d got %b@%0d exp 0100@1", n, rv, lat); end
      checks++; if (res !== bv[n]) begin errors++; $display("FAIL bypass_res%0d got %0d exp %0d", n, res, bv[n]); end
      checks++; if (ld_cnt !== 0) begin errors++; $display("FAIL bypass_ld%0d got %0d strobes exp 0", n, ld_cnt); end
      handshake(2);
    end
  endtask

  task automatic test_backpressure();
    logic [NREQ-1:0] gv, rv;
    logic [XLEN-1:0] res, la, lb;
    int waited, lat, ld_cnt, ld_at;
    pa[0] = 20; pb[0] = 8; vmask = 4'b0001; apply();
    wait_grant(gv, waited);
    @(posedge clk); #1;
    pa[1] = 9; pb[1] = 6; vmask = 4'b0010; apply();
    wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
    checks++; if (rv !== 4'b0001 || res !== 4) begin errors++; $display("FAIL bp_first got %b/%0d exp 0001/4", rv, res); end
    bus.rsp_ready_i = 4'b0010;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (bus.rsp_valid_o !== 4'b0001 || bus.rsp_gcd_o !== 4 || bus.req_ready_o !== '0) begin
        errors++; $display("FAIL bp_hold%0d got rsp %b/%0d rdy %b exp 0001/4 rdy 0000", k, bus.rsp_valid_o, bus.rsp_gcd_o, bus.req_ready_o);
      end
    end
    bus.rsp_ready_i = 4'b0001; #1;
    checks++; if (bus.req_ready_o !== '0) begin errors++; $display("FAIL bp_hs_ready got %b exp 0000", bus.req_ready_o); end
    @(posedge clk); #1;
    bus.rsp_ready_i = '0; exp_ptr = 1;
    wait_grant(gv, waited);
    checks++; if (gv !== 4'b0010 || waited !== 0) begin errors++; $display("FAIL bp_next_grant got %b after %0d exp 0010 after 0", gv, waited); end
    @(posedge clk); #1;
    vmask = '0; apply();
    wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
    checks++; if (rv !== 4'b0010 || res !== 3) begin errors++; $display("FAIL bp_second got %b/%0d exp 0010/3", rv, res); end
    handshake(1);
  endtask

  task automatic test_core_not_ready();
    logic [NREQ-1:0] gv, rv;
    logic [XLEN-1:0] res, la, lb;
    int waited, lat, ld_cnt, ld_at;
    core_hold = 1'b1; pa[3] = 84; pb[3] = 36; vmask = 4'b1000; apply();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (bus.req_ready_o !== '0 || busy_o !== 1'b0) begin errors++; $display("FAIL cnr_hold%0d got rdy %b busy %b exp 0000/0", k, bus.req_ready_o, busy_o); end
      @(posedge clk); #1;
    end
    core_hold = 1'b0;
    wait_grant(gv, waited);
    checks++; if (gv !== 4'b1000 || waited !== 0) begin errors++; $display("FAIL cnr_grant got %b after %0d exp 1000 after 0", gv, waited); end
    @(posedge clk); #1;
    vmask = '0; apply();
    wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
    checks++; if (rv !== 4'b1000 || res !== 12) begin errors++; $display("FAIL cnr_rsp got %b/%0d exp 1000/12", rv, res); end
    handshake(3);
  endtask

  task automatic test_reset_mid_op();
    logic [NREQ-1:0] gv, rv;
    logic [XLEN-1:0] res, la, lb;
    int waited, lat, ld_cnt, ld_at;
    // Move the pointer to 2 first so a restart from 0 is observable.
    pa[1] = 14; pb[1] = 21; vmask = 4'b0010; apply();
    wait_grant(gv, waited);
    @(posedge clk); #1;
    vmask = '0; apply();
    wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
    checks++; if (rv !== 4'b0010 || res !== 7) begin errors++; $display("FAIL rmo_pre got %b/%0d exp 0010/7", rv, res); end
    handshake(1);
    pa[2] = 12; pb[2] = 8; vmask = 4'b0100; apply();
    wait_grant(gv, waited);
    @(posedge clk); #1;
    vmask = '0; apply();
    @(posedge clk); #1;
    @(negedge clk);
    checks++; if (busy_o !== 1'b1 || owner_o !== 2) begin errors++; $display("FAIL rmo_wait got busy %b owner %0d exp 1/2", busy_o, owner_o); end
    #1 rst_i = 1'b1;
    #1;
    checks++;
    if ({bus.req_ready_o, bus.rsp_valid_o, bus.rsp_gcd_o, bus.gcd_ld_o, bus.gcd_a_o, bus.gcd_b_o, busy_o, owner_o} !== '0) begin
      errors++; $display("FAIL rmo_clear got busy %b owner %0d a %0d b %0d rsp %b exp all 0", busy_o, owner_o, bus.gcd_a_o, bus.gcd_b_o, bus.rsp_valid_o);
    end
    @(posedge clk); #1;
    rst_i = 1'b0; exp_ptr = 0;
    stray = 1'b1;
    @(posedge clk); #1;
    stray = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++; if (busy_o !== 1'b0 || bus.rsp_valid_o !== '0) begin errors++; $display("FAIL rmo_stray%0d got busy %b rsp %b exp 0/0000", k, busy_o, bus.rsp_valid_o); end
      @(posedge clk); #1;
    end
    pa[1] = 45; pb[1] = 30; pa[3] = 7; pb[3] = 3; vmask = 4'b1010; apply();
    wait_grant(gv, waited);
    checks++; if (gv !== 4'b0010) begin errors++; $display("FAIL rmo_grant got %b exp 0010", gv); end
    @(posedge clk); #1;
    vmask = '0; apply();
    wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
    checks++; if (rv !== 4'b0010 || res !== 15 || lat !== LC + 2) begin errors++; $display("FAIL rmo_rsp got %b/%0d@%0d exp 0010/15@%0d", rv, res, lat, LC + 2); end
    handshake(1);
  endtask

  task automatic test_random();
    logic [NREQ-1:0] gv, rv, ev;
    logic [XLEN-1:0] res, la, lb, er;
    int waited, lat, ld_cnt, ld_at, e, g, d, el;
    for (int it = 0; it < 40; it++) begin
      vmask = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        g = int'($urandom_range(1, 50));
        pa[i] = XLEN'(g * int'($urandom_range(1, 40)));
        pb[i] = XLEN'(g * int'($urandom_range(1, 40)));
        if ($urandom_range(0, 4) == 0) pa[i] = '0;
        if ($urandom_range(0, 6) == 0) pb[i] = '0;
      end
      apply();
      e = model_grant(vmask);
      ev = '0; ev[e] = 1'b1;
      er = model_result(pa[e], pb[e]);
      el = (pa[e] == 0 || pb[e] == 0) ? 1 : LC + 2;
      wait_grant(gv, waited);
      checks++; if (gv !== ev || waited !== 0) begin errors++; $display("FAIL rnd_grant%0d got %b after %0d exp %b after 0", it, gv, waited, ev); end
      @(posedge clk); #1;
      vmask[e] = 1'b0; apply();
      wait_rsp(lat, rv, res, ld_cnt, ld_at, la, lb);
      checks++; if (rv !== ev || res !== er || lat !== el) begin errors++; $display("FAIL rnd_rsp%0d got %b/%0d@%0d exp %b/%0d@%0d", it, rv, res, lat, ev, er, el); end
      d = int'($urandom_range(0, 3));
      bus.rsp_ready_i = NREQ'($urandom_range(0, (1 << NREQ) - 1)) & ~ev;
      for (int k = 0; k < d; k++) begin
        @(posedge clk); #1;
        @(negedge clk);
      end
      checks++; if (bus.rsp_valid_o !== ev || bus.rsp_gcd_o !== er) begin errors++; $display("FAIL rnd_hold%0d got %b/%0d exp %b/%0d", it, bus.rsp_valid_o, bus.rsp_gcd_o, ev, er); end
      handshake(e);
    end
    vmask = '0; apply();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    core_hold = 1'b0; stray = 1'b0;
    for (int i = 0; i < NREQ; i++) begin pa[i] = XLEN'(i + 3); pb[i] = XLEN'(i + 5); end
    vmask = '0;
    bus.rsp_ready_i = '0;
    apply();
    test_reset();
    test_fairness();
    test_single();
    test_bypass();
    test_backpressure();
    test_core_not_ready();
    test_reset_mid_op();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
